// File: rtl/keypad_scan4x4_pkg.sv
// Shared definitions for the column-multiplexed keypad scanner and display driver.
package keypad_scan4x4_pkg;

  // Multiplex slot length shared with the 7-segment driver so both run at the same rate.
  localparam int unsigned SCAN_DIV_DEFAULT = 1953;

  localparam logic [3:0] COL_OFF = 4'b1111;
  localparam logic [3:0][3:0] COL_PATTERNS = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [3:0] key_index(input logic [1:0] col, input logic [1:0] row);
    return {col, row};
  endfunction

  // Lowest-numbered set key in a 16-bit map; 0 when the map is empty.
  function automatic logic [3:0] lowest_key(input logic [15:0] map);
    logic [3:0] idx;
    idx = '0;
    for (int c = 3; c >= 0; c--) begin
      for (int r = 3; r >= 0; r--) begin
        if (map[key_index(2'(c), 2'(r))]) idx = key_index(2'(c), 2'(r));
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs; reset value is a parameter.
module sync2 #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner: column strobes, frame assembly, whole-map debounce, press events.
module keypad_scan4x4
  import keypad_scan4x4_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int unsigned DEB_CNT  = 4
) (
  input  logic        I_CLK,
  input  logic        I_RESET_N,
  input  logic [3:0]  I_ROW,
  output logic [3:0]  O_COL,
  output logic [3:0]  O_KEY,
  output logic        O_KEY_VLD,
  output logic [15:0] O_KEYMAP
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       col_idx;
  logic [3:0]       row_sync;
  logic [11:0]      asm_bits;
  logic [15:0]      prev_frame;
  logic [DEB_W-1:0] stable_cnt;
  logic             pend_vld;
  logic [3:0]       pend_key;

  logic             tick_c;
  logic             frame_end_c;
  logic             same_c;
  logic             accept_c;
  logic [3:0]       pressed_c;
  logic [15:0]      frame_c;
  logic [15:0]      new_keys_c;
  logic [DEB_W-1:0] stable_nxt_c;

  sync2 #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_row_sync (
    .clk  (I_CLK),
    .rst_n(I_RESET_N),
    .d    (I_ROW),
    .q    (row_sync)
  );

  // Tick/frame decode and debounce decision for the frame completing this cycle.
  always_comb begin
    tick_c       = (slot_cnt == CNT_LAST);
    frame_end_c  = tick_c && (col_idx == 2'd3);
    pressed_c    = ~row_sync;
    frame_c      = {pressed_c, asm_bits};
    same_c       = (frame_c == prev_frame);
    stable_nxt_c = '0;
    if (same_c) begin
      stable_nxt_c = (stable_cnt == DEB_LAST) ? stable_cnt : stable_cnt + DEB_W'(1);
    end
    accept_c     = frame_end_c && same_c && (stable_nxt_c == DEB_LAST);
    new_keys_c   = frame_c & ~O_KEYMAP;
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      slot_cnt   <= '0;
      col_idx    <= '0;
      asm_bits   <= '0;
      prev_frame <= '0;
      stable_cnt <= '0;
      pend_vld   <= 1'b0;
      pend_key   <= '0;
      O_COL      <= COL_OFF;
      O_KEY      <= '0;
      O_KEY_VLD  <= 1'b0;
      O_KEYMAP   <= '0;
    end else begin
      O_COL     <= COL_PATTERNS[col_idx];
      O_KEY_VLD <= pend_vld;
      if (pend_vld) O_KEY <= pend_key;
      pend_vld  <= 1'b0;
      slot_cnt  <= tick_c ? '0 : slot_cnt + CNT_W'(1);

      if (tick_c) begin
        col_idx <= col_idx + 2'd1;
        case (col_idx)
          2'd0:    asm_bits[3:0]  <= pressed_c;
          2'd1:    asm_bits[7:4]  <= pressed_c;
          2'd2:    asm_bits[11:8] <= pressed_c;
          default: ;
        endcase
      end

      // Column 3 is folded straight into frame_c, so the frame is judged on its own tick.
      if (frame_end_c) begin
        prev_frame <= frame_c;
        stable_cnt <= stable_nxt_c;
        if (accept_c) begin
          O_KEYMAP <= frame_c;
          if (|new_keys_c) begin
            pend_vld <= 1'b1;
            pend_key <= lowest_key(new_keys_c);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Directed bench for keypad_scan4x4 with a behavioural keypad matrix (SCAN_DIV=8, DEB_CNT=3).
module tb_keypad_scan4x4;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DEB_CNT  = 3;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;
  localparam int unsigned MAX_LAT  = (DEB_CNT + 1) * FRAME + 4;

  typedef struct {
    logic [15:0] keys;
    int unsigned frames;
    logic [15:0] exp_map;
    int unsigned exp_events;
    logic [3:0]  exp_key;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_vld;
  logic [15:0] keymap;
  logic [15:0] keys;

  int n_checks;
  int n_errors;
  int cyc;
  int ev_count;
  int ev_cyc;
  logic rst_applied;
  logic prev_vld;
  logic [3:0] prev_key;

  keypad_scan4x4 #(
    .SCAN_DIV(SCAN_DIV),
    .DEB_CNT (DEB_CNT)
  ) dut (
    .I_CLK    (clk),
    .I_RESET_N(rst_n),
    .I_ROW    (row),
    .O_COL    (col),
    .O_KEY    (key),
    .O_KEY_VLD(key_vld),
    .O_KEYMAP (keymap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key at (c,r) pulls row r low while column c is strobed.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[4*c+r] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_applied <= !rst_n;
  end

  // Event monitor: single-cycle pulses, and O_KEY moves only together with a pulse.
  always @(negedge clk) begin
    if (rst_n && !rst_applied) begin
      if (key_vld) begin
        ev_count++;
        ev_cyc = cyc;
        check("vld_not_consecutive", 32'(prev_vld), 32'(0));
      end else begin
        check("key_stable_without_vld", 32'(key), 32'(prev_key));
      end
    end
    prev_vld = key_vld;
    prev_key = key;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    logic [3:0] col_exp[4];
    int ev_before;
    int start;
    int k;
    int lat;

    vecs[0] = '{16'h0000,  4, 16'h0000, 0, 4'd0};
    vecs[1] = '{16'h0200,  6, 16'h0200, 1, 4'd9};
    vecs[2] = '{16'h0200, 10, 16'h0200, 0, 4'd9};
    vecs[3] = '{16'h0000,  6, 16'h0000, 0, 4'd9};
    vecs[4] = '{16'h4010,  6, 16'h4010, 1, 4'd4};
    vecs[5] = '{16'h0000,  6, 16'h0000, 0, 4'd4};
    vecs[6] = '{16'h0020,  6, 16'h0020, 1, 4'd5};
    vecs[7] = '{16'h0400,  6, 16'h0400, 1, 4'd10};
    vecs[8] = '{16'h8001,  6, 16'h8001, 1, 4'd0};
    vecs[9] = '{16'h0000,  6, 16'h0000, 0, 4'd0};
    col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    ev_count = 0;
    ev_cyc = 0;
    keys = '0;
    rst_n = 1'b0;
    step(3);
    check("reset_col", 32'(col), 32'(4'b1111));
    check("reset_key", 32'(key), 32'(0));
    check("reset_vld", 32'(key_vld), 32'(0));
    check("reset_map", 32'(keymap), 32'(0));

    // Column k-th edge after release shows slot (k-1)/SCAN_DIV.
    rst_n = 1'b1;
    for (int i = 1; i <= 2 * int'(FRAME); i++) begin
      step(1);
      check($sformatf("col_seq_%0d", i), 32'(col), 32'(col_exp[((i - 1) / SCAN_DIV) % 4]));
    end

    for (int i = 0; i < 10; i++) begin
      ev_before = ev_count;
      start = cyc;
      keys = vecs[i].keys;
      step(int'(vecs[i].frames * FRAME));
      check($sformatf("vec%0d_map", i), 32'(keymap), 32'(vecs[i].exp_map));
      check($sformatf("vec%0d_events", i), 32'(ev_count - ev_before), 32'(vecs[i].exp_events));
      check($sformatf("vec%0d_key", i), 32'(key), 32'(vecs[i].exp_key));
      if (vecs[i].exp_events == 1) begin
        lat = ev_cyc - start;
        check($sformatf("vec%0d_latency_in_bound(lat=%0d)", i, lat),
              32'(lat > 0 && lat <= int'(MAX_LAT)), 32'(1));
      end
    end

    // Bounce on key (0,3): alternate each frame, ending released, then hold.
    ev_before = ev_count;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      step(int'(FRAME));
    end
    check("bounce_no_event", 32'(ev_count - ev_before), 32'(0));
    check("bounce_map_unchanged", 32'(keymap), 32'(0));
    keys = 16'h0008;
    k = 0;
    while (!key_vld && k < 300) begin
      step(1);
      k++;
    end
    check($sformatf("bounce_event_seen(k=%0d)", k), 32'(key_vld), 32'(1));
    check($sformatf("bounce_latency(k=%0d)", k), 32'(k > 2 * int'(FRAME) && k <= int'(MAX_LAT)), 32'(1));
    check("bounce_key", 32'(key), 32'(3));
    check("bounce_map", 32'(keymap), 32'(16'h0008));
    step(3 * int'(FRAME));
    check("bounce_single_event", 32'(ev_count - ev_before), 32'(1));
    keys = 16'h0000;
    step(6 * int'(FRAME));
    check("bounce_release_map", 32'(keymap), 32'(0));
    check("bounce_release_key", 32'(key), 32'(3));

    // One-cycle reset during the debounce of key (0,0), key held throughout.
    ev_before = ev_count;
    keys = 16'h0001;
    step(40);
    check("pre_reset_no_event", 32'(ev_count - ev_before), 32'(0));
    rst_n = 1'b0;
    step(1);
    check("midreset_col", 32'(col), 32'(4'b1111));
    check("midreset_key", 32'(key), 32'(0));
    check("midreset_vld", 32'(key_vld), 32'(0));
    check("midreset_map", 32'(keymap), 32'(0));
    rst_n = 1'b1;
    // Fresh scan: frames end at edges 32, 64, 96; third identical frame accepts, pulse on edge 97.
    k = 0;
    while (!key_vld && k < 300) begin
      step(1);
      k++;
    end
    check("reset_event_latency", 32'(k), 32'(3 * FRAME + 1));
    check("reset_event_key", 32'(key), 32'(0));
    check("reset_event_map", 32'(keymap), 32'(16'h0001));
    step(2 * int'(FRAME));
    check("reset_single_event", 32'(ev_count - ev_before), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan4x4.md
# keypad_scan4x4

- Scans a 4x4 matrix keypad: drives one-cold column strobes, samples active-low row inputs, debounces the whole 16-key map and reports each new key press as a 4-bit code with a one-cycle valid pulse.
- It is the input-side counterpart of the multiplexed 7-segment display driver: same column-multiplexed board I/O, same slot timing, but reading instead of driving.
- Key codes feed the counter/display logic directly; the 4-bit code matches the display driver's digit input width.

## Interface
Parameters:
- SCAN_DIV, 1953: clock cycles per column slot. Must be ≥ 4.
- DEB_CNT, 4: number of identical consecutive frames needed to accept a new key map. Range 2..15.

Ports:
- I_CLK  in  1  system clock, single clock domain.
- I_RESET_N  in  1  reset, synchronous, active-low.
- I_ROW  in  4  keypad rows, active-low, pulled up on the board, asynchronous to I_CLK.
- O_COL  out  4  column strobes, one-cold, registered.
- O_KEY  out  4  code of the last newly pressed key: 4*col + row.
- O_KEY_VLD  out  1  one-cycle pulse; O_KEY is valid on this cycle.
- O_KEYMAP  out  16  debounced pressed map; bit 4*col+row = 1 means the key is pressed.

## Operation
- **Slot counter:** counts 0..SCAN_DIV-1 and wraps. The end-of-slot tick is when the count equals SCAN_DIV-1.
- **Column index:** 2 bits, increments on each tick and wraps 3→0.
- **O_COL:** registered decode of the column index: 0→1110, 1→1101, 2→1011, 3→0111.
- **Row input:** I_ROW passes through a 2-FF synchronizer (reset value 1111). The synchronized value is inverted to give pressed = 1.
- **Sampling:** on the tick, the synchronized rows are written into frame-assembly bits [4*col+3 : 4*col] for the current column. The column has been driven for SCAN_DIV-1 cycles before this sample.
- **Frame end:** the tick of column 3. At frame end, the assembled 16 bits are compared with the previous frame register P, then P is loaded with the assembled bits.
- **Stability counter S:**
  - Increments, saturating at DEB_CNT-1, when the new frame equals P.
  - Clears to 0 otherwise.
- **Debounced map update:** at the frame end where S would reach DEB_CNT-1, O_KEYMAP loads the frame. DEB_CNT identical consecutive frames are therefore required. Each further identical frame reloads the same value, with no effect.
- **Press detection:** N = new map & ~old map, evaluated when O_KEYMAP updates.
  - If N ≠ 0: O_KEY = index of the lowest set bit of N, and O_KEY_VLD = 1 on the next cycle.
  - Other simultaneously new keys appear in O_KEYMAP only; no event is generated for them.
- **Release:** clears O_KEYMAP bits after the same debounce. No event, and O_KEY holds its value.
- **Held key:** no repeat events.
- **Bounce:** any frame differing from P restarts the debounce. O_KEYMAP is unchanged until stable.

## Timing
Reset values, one cycle after the I_RESET_N=0 edge:
- O_COL=1111, O_KEY=0, O_KEY_VLD=0, O_KEYMAP=0.
- Slot counter, column index, S, P and assembly bits all 0. Synchronizer = 1111.
- First O_COL=1110 on the first edge after reset release.

Frame and latency:
- Frame period = 4*SCAN_DIV cycles.
- Latency from a clean press to O_KEY_VLD: at most (DEB_CNT+1) frames + 4 cycles (2 for the synchronizer, 1 for the map register, 1 for the pulse).
- O_KEY_VLD is high for exactly one cycle, never on consecutive cycles. O_KEY changes only on the cycle O_KEY_VLD rises.

Boundary conditions:
- Reset mid-scan: all state is lost. Scanning restarts at column 0, and any pending debounce is discarded.
- A simultaneous press and release in the same debounced update: an event is raised for the press only.
- Row change exactly on the tick: the synchronizer output at that edge is what gets sampled. Metastability is confined to the first synchronizer flop.

## Structure
- Shared package holds:
  - the column one-cold patterns;
  - the key index function (4*col+row);
  - default SCAN_DIV, which is shared with the display driver so both use the same multiplex rate.
- One sub-module, `sync2`: a 2-FF synchronizer with width parameter and reset value parameter. It is reusable for other board inputs.
- Everything else lives in a single module: slot counter, column index, assembly/debounce, and event encoder.

## Test plan
Simulation uses SCAN_DIV=8 and DEB_CNT=3. A keypad model connects row r low while O_COL[c]=0 for each pressed key (c,r).
- Reset → O_COL=1111 during reset. After release, O_COL cycles 1110,1101,1011,0111 with 8 cycles per slot. O_KEYMAP=0 and no O_KEY_VLD.
- Press key (2,1) cleanly → exactly one O_KEY_VLD with O_KEY=9 within 4 frames + 4 cycles. O_KEYMAP=0x0200. No further pulse while the key is held for 10 frames.
- Bounce: toggle key (0,3) every frame for 5 frames, then hold → no event during the bounce. A single event O_KEY=3 arrives 3 stable frames after the hold begins.
- Press keys (1,0) and (3,2) in the same frame → one event with O_KEY=4. O_KEYMAP=0x4010.
- Release all keys → O_KEYMAP returns to 0 after 3 stable frames, with no O_KEY_VLD and O_KEY unchanged.
- Assert I_RESET_N=0 mid-debounce of key (0,0) for 1 cycle, holding the key afterwards → outputs return to reset values. The event O_KEY=0 arrives only after a full fresh debounce measured from release.
